// File: rtl/reg_file_wb.sv
// reg_file_wb: 32-entry GPR file with write-through bypass and load scoreboard.
// Define REGFILE_DEBUG_EN for the dbg_num/dbg_data/wb_count debug ports.
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_num,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] rs_num,
  input  logic [ADDR_W-1:0] rt_num,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_num,
  output logic              stall
`ifdef REGFILE_DEBUG_EN
  ,
  input  logic [ADDR_W-1:0] dbg_num,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wb_count
`endif
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                wr_en;
  logic                rs_hz;
  logic                rt_hz;

  assign wr_en = we && (write_num != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[write_num] <= write_data;
    end
  end

  // Set is applied last so a newer load wins over a retiring write.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[write_num] = 1'b0;
    end
    if (busy_set && (busy_num != '0)) begin
      busy_d[busy_num] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rst_n && (rs_num != '0)) begin
      if (wr_en && (write_num == rs_num)) begin
        rs_data = write_data;
      end else begin
        rs_data = regs_q[rs_num];
      end
    end
    if (rst_n && (rt_num != '0)) begin
      if (wr_en && (write_num == rt_num)) begin
        rt_data = write_data;
      end else begin
        rt_data = regs_q[rt_num];
      end
    end
  end

  always_comb begin
    rs_hz = busy_q[rs_num] && (rs_num != '0) &&
            !(wr_en && (write_num == rs_num));
    rt_hz = busy_q[rt_num] && (rt_num != '0) &&
            !(wr_en && (write_num == rt_num));
    stall = rst_n && (rs_hz || rt_hz);
  end

`ifdef REGFILE_DEBUG_EN
  logic [31:0] wb_count_q;
  logic [31:0] wb_count_d;

  assign wb_count_d = wr_en ? wb_count_q + 32'd1 : wb_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count_q <= '0;
    end else begin
      wb_count_q <= wb_count_d;
    end
  end

  assign wb_count = wb_count_q;
  assign dbg_data = (dbg_num == '0) ? '0 : regs_q[dbg_num];
`endif

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed stimulus, array model and per-cycle comparison.
// Build with REGFILE_DEBUG_EN defined to also cover the debug ports.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  write_num;
  logic [31:0] write_data;
  logic [4:0]  rs_num;
  logic [4:0]  rt_num;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy_set;
  logic [4:0]  busy_num;
  logic        stall;
`ifdef REGFILE_DEBUG_EN
  logic [4:0]  dbg_num;
  logic [31:0] dbg_data;
  logic [31:0] wb_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  reg_file_wb #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .write_num  (write_num),
    .write_data (write_data),
    .rs_num     (rs_num),
    .rt_num     (rt_num),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .busy_set   (busy_set),
    .busy_num   (busy_num),
    .stall      (stall)
`ifdef REGFILE_DEBUG_EN
    ,
    .dbg_num    (dbg_num),
    .dbg_data   (dbg_data),
    .wb_count   (wb_count)
`endif
  );

  // Architectural model: plain arrays updated by the rules of the ISA.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [31:0] m_count;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_busy[i] = 1'b0;
      end
      m_count = 32'd0;
    end else begin
      if (we && write_num != 0) begin
        m_regs[write_num] = write_data;
        m_busy[write_num] = 1'b0;
        m_count = m_count + 32'd1;
      end
      if (busy_set && busy_num != 0) m_busy[busy_num] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] n);
    if (!rst_n || n == 0) return 32'd0;
    if (we && write_num == n) return write_data;
    return m_regs[n];
  endfunction

  function automatic logic exp_hz(input logic [4:0] n);
    return m_busy[n] && n != 0 && !(we && write_num == n);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_rs", rs_data, exp_rd(rs_num));
    chk("cmp_rt", rt_data, exp_rd(rt_num));
    chk("cmp_stall", {31'd0, stall},
        {31'd0, rst_n && (exp_hz(rs_num) || exp_hz(rt_num))});
`ifdef REGFILE_DEBUG_EN
    chk("cmp_dbg", dbg_data, (dbg_num == 0) ? 32'd0 : m_regs[dbg_num]);
    chk("cmp_cnt", wb_count, m_count);
`endif
  end

  task automatic step(input logic w, input logic [4:0] wn,
                      input logic [31:0] wd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic bs,
                      input logic [4:0] bn);
    @(posedge clk);
    #1;
    we = w; write_num = wn; write_data = wd;
    rs_num = rs; rt_num = rt; busy_set = bs; busy_num = bn;
  endtask

  initial begin
    rst_n = 1'b0;
    we = 0; write_num = 0; write_data = 0;
    rs_num = 0; rt_num = 0; busy_set = 0; busy_num = 0;
`ifdef REGFILE_DEBUG_EN
    dbg_num = 0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 5'(i), 5'(31 - i), 0, 0);
      #1;
      chk("rst_rs", rs_data, 32'd0);
      chk("rst_rt", rt_data, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
    end

    step(1, 5, 32'hDEAD_BEEF, 5, 0, 0, 0);
    #1 chk("bypass_rs", rs_data, 32'hDEAD_BEEF);
    step(0, 0, 0, 5, 5, 0, 0);
    #1 chk("held_rs", rs_data, 32'hDEAD_BEEF);
    chk("held_rt", rt_data, 32'hDEAD_BEEF);
`ifdef REGFILE_DEBUG_EN
    dbg_num = 5;
    #1 chk("dbg_5", dbg_data, 32'hDEAD_BEEF);
`endif

    step(1, 0, 32'h1234, 0, 0, 0, 0);
    #1 chk("r0_bypass", rs_data, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    #1 chk("r0_read", rs_data, 32'd0);
`ifdef REGFILE_DEBUG_EN
    chk("cnt_r0", wb_count, 32'd1);
`endif

    step(0, 0, 0, 0, 0, 1, 8);
    step(0, 0, 0, 0, 8, 0, 0);
    #1 chk("busy8_a", {31'd0, stall}, 32'd1);
    step(0, 0, 0, 0, 8, 0, 0);
    #1 chk("busy8_b", {31'd0, stall}, 32'd1);
    step(1, 8, 32'hCAFE_0008, 0, 8, 0, 0);
    #1 chk("busy8_wb", {31'd0, stall}, 32'd0);
    chk("busy8_data", rt_data, 32'hCAFE_0008);
    step(0, 0, 0, 0, 8, 0, 0);
    #1 chk("busy8_clr", {31'd0, stall}, 32'd0);

    step(1, 9, 32'h99, 0, 0, 1, 9);
    step(0, 0, 0, 9, 0, 0, 0);
    #1 chk("set_wins", {31'd0, stall}, 32'd1);
    step(1, 9, 32'h9A, 9, 0, 0, 0);
    #1 chk("r9_byp", rs_data, 32'h9A);

    step(0, 0, 0, 0, 0, 1, 10);
    step(0, 0, 0, 10, 10, 0, 0);
    #1 chk("dual_stall", {31'd0, stall}, 32'd1);
    step(1, 10, 32'hAA, 10, 10, 0, 0);
    #1 chk("dual_rs", rs_data, 32'hAA);
    chk("dual_rt", rt_data, 32'hAA);

    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    #1 chk("bs_r0", {31'd0, stall}, 32'd0);

    step(1, 3, 32'd7, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 4);
    step(0, 0, 0, 3, 4, 0, 0);
    #1 chk("pre_rst_rs", rs_data, 32'd7);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_rs", rs_data, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
`ifdef REGFILE_DEBUG_EN
    chk("mid_rst_cnt", wb_count, 32'd0);
`endif
    #2 rst_n = 1'b1;
    step(0, 0, 0, 3, 4, 0, 0);
    #1 chk("post_rst_rs", rs_data, 32'd0);
    chk("post_rst_stall", {31'd0, stall}, 32'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
